i8088_bus_cycle_ctrl: RTL and testbench
=======================================

// Module: i8088_bus_cycle_ctrl
// PURPOSE
//  Sequences every 8088 bus cycle seen on the FPGA header pins. Latches the address during ALE
//  and decodes IO/nM. Forwards each read/write as a single-pulse req/ack transaction to the memory
//  or IO target fabric. Holds READY low until the target answers or a timeout expires, and drives
//  AD7..0 on reads. Sits between the pin-level bus and the ROM/SRAM/DDR/UART/PS2 targets.
// PARAMETERS
//  SYNC_STAGES  2     flip-flop stages on ale/nrd/nwr/io_nm inputs (>=2)
//  TIMEOUT      1023  clk cycles in WAIT before a cycle is force-completed (1..65535)
//  TO_DATA      8'hFF read data returned on timeout
// PORTS
//  clk           in   1   system clock (100 MHz)
//  resetn        in   1   asynchronous active-low reset
//  ale           in   1   8088 ALE (async)
//  nrd           in   1   8088 nRD (async, active low)
//  nwr           in   1   8088 nWR (async, active low)
//  io_nm         in   1   8088 IO/nM (async)
//  a_hi          in   12  A19..A8 from pins
//  ad_in         in   8   AD7..0 from pins (address during ALE, write data during nWR)
//  ad_out        out  8   read data to pins
//  ad_oe         out  1   1 = FPGA drives AD7..0
//  ready         out  1   8088 READY (0 = insert wait states)
//  mem_req       out  1   one-cycle memory request pulse
//  io_req        out  1   one-cycle IO request pulse
//  tgt_we        out  1   1 = write, valid with req
//  tgt_addr      out  20  A19..A0 (IO targets use [15:0])
//  tgt_wdata     out  8   write data, valid with req
//  mem_ack       in   1   memory target completion (1 cycle)
//  mem_rdata     in   8   valid with mem_ack on reads
//  io_ack        in   1   IO target completion (1 cycle)
//  io_rdata      in   8   valid with io_ack on reads
//  timeout_pulse out  1   one-cycle pulse when a cycle times out
// BEHAVIOUR
//  Reset: ready=1, ad_oe=0, ad_out=0, mem_req=io_req=0, tgt_we=0, tgt_addr=0, tgt_wdata=0,
//   timeout_pulse=0, state IDLE, timeout counter 0. Reset is honoured in any state; an ack that
//   arrives after reset is ignored.
//  Address latch: every clk while synced ale=1, tgt_addr <= {a_hi, ad_in}. Value frozen on ale fall.
//  States:
//   - IDLE: ready=1, ad_oe=0. Start condition: synced ale=0 and exactly one of nrd/nwr low.
//     Capture io_nm, tgt_we=!nwr_s, tgt_wdata<=ad_in. Both strobes low is ignored: stay IDLE,
//     ready stays 1, no req. Goto REQ.
//   - REQ: one cycle. mem_req=!io_nm or io_req=io_nm; ready=0; clear timeout counter.
//     Goto WAIT.
//   - WAIT: ready=0. Only the ack of the issued class counts.
//     On ack: if read, ad_out<=rdata; goto HOLD. On an ack in the same cycle as counter==TIMEOUT,
//     the ack wins. When the counter reaches TIMEOUT with no ack: ad_out<=TO_DATA (reads only),
//     timeout_pulse=1 for one cycle, goto HOLD.
//   - HOLD: ready=1; ad_oe=1 while read cycle and nrd_s=0. When nrd_s=1 and nwr_s=1, ad_oe=0 and
//     goto IDLE. Synced ale=1 also forces IDLE (abort; no second req).
//  Latency: pin strobe fall -> req pulse at SYNC_STAGES+1 clk. ready falls in the req cycle and
//   rises the clk after the ack. ad_oe falls within SYNC_STAGES+1 clk of nRD rise.
//  Exactly one req per bus cycle. tgt_addr/tgt_we/tgt_wdata are stable from REQ through
//   completion. Timeout counter is 16 bit and saturates; it never wraps.
// TESTING
//  1 Mem read A=FFFF0, mem_ack 5 clk after req with EA -> one mem_req, addr FFFF0, we=0; ready
//    low until ack+1; ad_out=EA; ad_oe=1 until nRD high.
//  2 IO write A=0x00082 D=01, io_ack same clk as req -> io_req, we=1, wdata=01; ready rises;
//    ad_oe stays 0.
//  3 IO read A=0x0200, no ack -> ready low for TIMEOUT clk, then 1; ad_out=FF; timeout_pulse once.
//  4 nRD and nWR both low after ALE -> no req, ready remains 1.
//  5 resetn low during WAIT, late mem_ack after release -> all outputs reset values, ack ignored;
//    next read completes normally.
//  6 Back-to-back reads 0x00000 (ack 11) then 0x00008 (ack 22) -> one req each, ad_out 11 then 22.

Source files
------------

// File: rtl/i8088_bus_cycle_ctrl_if.sv
// Pin-level 8088 bus plus the req/ack target handshake, bundled for the bus cycle controller.
// master = controller view, slave = pins/targets view.
interface i8088_bus_cycle_ctrl_if;
  logic        ale;
  logic        nrd;
  logic        nwr;
  logic        io_nm;
  logic [11:0] a_hi;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic        ready;
  logic        mem_req;
  logic        io_req;
  logic        tgt_we;
  logic [19:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        timeout_pulse;

  modport master (
    input  ale, nrd, nwr, io_nm, a_hi, ad_in,
    input  mem_ack, mem_rdata, io_ack, io_rdata,
    output ad_out, ad_oe, ready, mem_req, io_req,
    output tgt_we, tgt_addr, tgt_wdata, timeout_pulse
  );

  modport slave (
    output ale, nrd, nwr, io_nm, a_hi, ad_in,
    output mem_ack, mem_rdata, io_ack, io_rdata,
    input  ad_out, ad_oe, ready, mem_req, io_req,
    input  tgt_we, tgt_addr, tgt_wdata, timeout_pulse
  );
endinterface

// File: rtl/i8088_bus_cycle_ctrl.sv
// 8088 bus cycle sequencer: synchronises the pin strobes, issues one req pulse per cycle to the
// memory or IO fabric, stretches READY until ack or timeout, and drives read data back onto AD.
module i8088_bus_cycle_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 1023,
  parameter logic [7:0] TO_DATA     = 8'hFF
) (
  input logic                    clk,
  input logic                    resetn,
  i8088_bus_cycle_ctrl_if.master bus
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_REQ  = 2'd1;
  localparam logic [1:0]  S_WAIT = 2'd2;
  localparam logic [1:0]  S_HOLD = 2'd3;
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  logic [SYNC_STAGES-1:0] ale_sr, nrd_sr, nwr_sr, ion_sr;
  logic        ale_s, nrd_s, nwr_s, ion_s;
  logic [1:0]  state;
  logic        cls_io, we_q, tp_q;
  logic [15:0] cnt;
  logic [19:0] addr_q;
  logic [7:0]  wd_q, rd_q;
  logic        ack, start;
  logic [7:0]  rdata;

  // Synchronisers reset to the idle pin levels so no phantom strobe appears after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ale_sr <= '0;
      nrd_sr <= '1;
      nwr_sr <= '1;
      ion_sr <= '0;
    end else begin
      ale_sr <= {ale_sr[SYNC_STAGES-2:0], bus.ale};
      nrd_sr <= {nrd_sr[SYNC_STAGES-2:0], bus.nrd};
      nwr_sr <= {nwr_sr[SYNC_STAGES-2:0], bus.nwr};
      ion_sr <= {ion_sr[SYNC_STAGES-2:0], bus.io_nm};
    end
  end

  assign ale_s = ale_sr[SYNC_STAGES-1];
  assign nrd_s = nrd_sr[SYNC_STAGES-1];
  assign nwr_s = nwr_sr[SYNC_STAGES-1];
  assign ion_s = ion_sr[SYNC_STAGES-1];

  assign ack   = cls_io ? bus.io_ack   : bus.mem_ack;
  assign rdata = cls_io ? bus.io_rdata : bus.mem_rdata;
  assign start = !ale_s && (nrd_s ^ nwr_s);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cls_io <= 1'b0;
      we_q   <= 1'b0;
      wd_q   <= '0;
      rd_q   <= '0;
      addr_q <= '0;
      cnt    <= '0;
      tp_q   <= 1'b0;
    end else begin
      tp_q <= 1'b0;
      if (ale_s)
        addr_q <= {bus.a_hi, bus.ad_in};
      case (state)
        S_IDLE: if (start) begin
          cls_io <= ion_s;
          we_q   <= !nwr_s;
          wd_q   <= bus.ad_in;
          state  <= S_REQ;
        end
        // A target may answer in the same cycle as the req pulse.
        S_REQ: begin
          cnt <= '0;
          if (ack) begin
            if (!we_q) rd_q <= rdata;
            state <= S_HOLD;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack) begin
            if (!we_q) rd_q <= rdata;
            state <= S_HOLD;
          end else if (cnt == TO_CNT) begin
            if (!we_q) rd_q <= TO_DATA;
            tp_q  <= 1'b1;
            state <= S_HOLD;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        S_HOLD: if (ale_s || (nrd_s && nwr_s)) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req       = (state == S_REQ) && !cls_io;
  assign bus.io_req        = (state == S_REQ) && cls_io;
  assign bus.ready         = !((state == S_REQ) || (state == S_WAIT));
  assign bus.ad_oe         = (state == S_HOLD) && !we_q && !nrd_s;
  assign bus.ad_out        = rd_q;
  assign bus.tgt_we        = we_q;
  assign bus.tgt_addr      = addr_q;
  assign bus.tgt_wdata     = wd_q;
  assign bus.timeout_pulse = tp_q;

endmodule

// File: tb/tb_i8088_bus_cycle_ctrl.sv
// Randomised bench: stimulus pushes expected reqs/read data into queues, monitors pop and compare.
module tb_i8088_bus_cycle_ctrl;
  localparam int SS = 2;
  localparam int TO = 20;

  typedef struct packed {
    logic        io;
    logic        we;
    logic [19:0] addr;
    logic [7:0]  wd;
  } req_t;

  typedef struct packed {
    logic       ack;
    logic [7:0] dly;
    logic [7:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  i8088_bus_cycle_ctrl_if bus();

  i8088_bus_cycle_ctrl #(.SYNC_STAGES(SS), .TIMEOUT(TO), .TO_DATA(8'hFF)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int tp_seen = 0;
  int tp_exp = 0;
  req_t       req_q[$];
  resp_t      resp_q[$];
  logic [7:0] rd_q[$];
  logic       oe_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Request / read-data / timeout monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.mem_req || bus.io_req) begin
        chk("req_exclusive", {31'd0, bus.mem_req & bus.io_req}, 32'd0);
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got req addr %0h expected none", bus.tgt_addr);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_class", {31'd0, bus.io_req}, {31'd0, e.io});
          chk("req_addr", {12'd0, bus.tgt_addr}, {12'd0, e.addr});
          chk("req_we", {31'd0, bus.tgt_we}, {31'd0, e.we});
          if (e.we) chk("req_wdata", {24'd0, bus.tgt_wdata}, {24'd0, e.wd});
        end
      end
      if (bus.timeout_pulse) tp_seen++;
      if (bus.ad_oe && !oe_prev) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ad_oe_unexpected: got ad_oe=1 expected 0");
        end else begin
          logic [7:0] d;
          d = rd_q.pop_front();
          chk("read_data", {24'd0, bus.ad_out}, {24'd0, d});
        end
      end
      oe_prev = bus.ad_oe;
    end else begin
      oe_prev = 1'b0;
    end
  end

  // Target responder: acks the issued class after the scheduled delay.
  always begin
    @(negedge clk);
    if (resetn && (bus.mem_req || bus.io_req) && resp_q.size() > 0) begin
      resp_t r;
      logic  io;
      r  = resp_q.pop_front();
      io = bus.io_req;
      if (r.ack) begin
        repeat (int'(r.dly)) @(negedge clk);
        if (io) begin bus.io_ack = 1'b1; bus.io_rdata = r.data; end
        else begin bus.mem_ack = 1'b1; bus.mem_rdata = r.data; end
        @(negedge clk);
        bus.io_ack  = 1'b0;
        bus.mem_ack = 1'b0;
        bus.io_rdata  = 8'($urandom);
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  task automatic addr_phase(input bit io, input logic [19:0] addr);
    @(negedge clk);
    bus.ale = 1'b1; bus.io_nm = io; bus.a_hi = addr[19:8]; bus.ad_in = addr[7:0];
    repeat (4) @(negedge clk);
    bus.ale = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // dly < 0 means the target never answers.
  task automatic bus_cycle(input bit io, input bit we, input logic [19:0] addr,
                           input logic [7:0] wd, input int dly, input logic [7:0] rd);
    int n;
    addr_phase(io, addr);
    bus.ad_in = we ? wd : 8'($urandom);
    req_q.push_back('{io: io, we: we, addr: addr, wd: wd});
    resp_q.push_back('{ack: (dly >= 0), dly: 8'((dly < 0) ? 0 : dly), data: rd});
    if (!we) rd_q.push_back((dly >= 0) ? rd : 8'hFF);
    if (dly < 0) tp_exp++;
    if (we) bus.nwr = 1'b0; else bus.nrd = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ready && n < 20);
    chk("req_latency", n, SS + 1);
    n = 0;
    while (!bus.ready && n < TO + 50) begin n++; @(negedge clk); end
    if (dly >= 0) chk("ready_low_cycles", n, dly + 1);
    else begin
      checks++;
      if (n < TO || n > TO + 2) begin
        errors++;
        $display("FAIL timeout_ready_low: got %0d expected %0d..%0d", n, TO, TO + 2);
      end
    end
    chk("ad_oe_hold", {31'd0, bus.ad_oe}, {31'd0, !we});
    repeat (3) @(negedge clk);
    chk("ad_oe_held", {31'd0, bus.ad_oe}, {31'd0, !we});
    chk("ready_hold", {31'd0, bus.ready}, 32'd1);
    bus.nrd = 1'b1; bus.nwr = 1'b1;
    repeat (SS + 1) @(negedge clk);
    chk("ad_oe_release", {31'd0, bus.ad_oe}, 32'd0);
    repeat (2) @(negedge clk);
    chk("timeout_pulses", tp_seen, tp_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ale = 1'b0; bus.nrd = 1'b1; bus.nwr = 1'b1; bus.io_nm = 1'b0;
    bus.a_hi = '0; bus.ad_in = '0;
    bus.mem_ack = 1'b0; bus.io_ack = 1'b0; bus.mem_rdata = '0; bus.io_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_ad_oe", {31'd0, bus.ad_oe}, 32'd0);
    chk("rst_ad_out", {24'd0, bus.ad_out}, 32'd0);
    chk("rst_req", {30'd0, bus.mem_req, bus.io_req}, 32'd0);
    chk("rst_addr", {12'd0, bus.tgt_addr}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    bus_cycle(1'b0, 1'b0, 20'hFFFF0, 8'h00, 5, 8'hEA);
    bus_cycle(1'b1, 1'b1, 20'h00082, 8'h01, 0, 8'h00);
    bus_cycle(1'b1, 1'b0, 20'h00200, 8'h00, -1, 8'h00);

    // Both strobes low together: no cycle may start.
    addr_phase(1'b0, 20'h12345);
    bus.nrd = 1'b0; bus.nwr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("both_low_ready", {31'd0, bus.ready}, 32'd1);
    end
    bus.nrd = 1'b1; bus.nwr = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in WAIT, then a stale ack after release.
    addr_phase(1'b0, 20'h4A5A5);
    req_q.push_back('{io: 1'b0, we: 1'b0, addr: 20'h4A5A5, wd: 8'h00});
    resp_q.push_back('{ack: 1'b0, dly: 8'd0, data: 8'h00});
    bus.nrd = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ready && n < 20);
    chk("rst_test_req_latency", n, SS + 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("wait_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("wait_rst_ad_oe", {31'd0, bus.ad_oe}, 32'd0);
    chk("wait_rst_we", {31'd0, bus.tgt_we}, 32'd0);
    chk("wait_rst_addr", {12'd0, bus.tgt_addr}, 32'd0);
    chk("wait_rst_wdata", {24'd0, bus.tgt_wdata}, 32'd0);
    chk("wait_rst_tp", {31'd0, bus.timeout_pulse}, 32'd0);
    chk("wait_rst_ad_out", {24'd0, bus.ad_out}, 32'd0);
    bus.nrd = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stale_ack_ready", {31'd0, bus.ready}, 32'd1);
      chk("stale_ack_ad_oe", {31'd0, bus.ad_oe}, 32'd0);
    end
    bus_cycle(1'b0, 1'b0, 20'h00100, 8'h00, 3, 8'hC3);

    bus_cycle(1'b0, 1'b0, 20'h00000, 8'h00, 2, 8'h11);
    bus_cycle(1'b0, 1'b0, 20'h00008, 8'h00, 3, 8'h22);

    for (int i = 0; i < 16; i++) begin
      bit io, we;
      int dly;
      io  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 8));
      bus_cycle(io, we, 20'($urandom), 8'($urandom), dly, 8'($urandom));
    end

    chk("req_q_drained", req_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
